// File: rtl/round_key_sched_if.sv
// Key-path bundle between the upstream round-key FIFO, the scheduler and the
// add-round-key key FIFO. The reload request is present only when KEY_RELOAD_EN is defined.
interface round_key_sched_if;
    logic [127:0] key_in;
    logic         key_in_rd;
    logic         key_in_empty;
    logic [127:0] round_key;
    logic         round_key_wr;
    logic         round_key_full;
    logic [3:0]   round_idx;
    logic         last_round;
    logic         loaded;
    logic [15:0]  blk_count;
`ifdef KEY_RELOAD_EN
    logic         reload;
`endif

    // master: the scheduler itself; slave: the surrounding FIFOs / control.
    modport master (
        input  key_in, key_in_empty, round_key_full,
`ifdef KEY_RELOAD_EN
        input  reload,
`endif
        output key_in_rd, round_key, round_key_wr, round_idx, last_round, loaded, blk_count
    );

    modport slave (
        output key_in, key_in_empty, round_key_full,
`ifdef KEY_RELOAD_EN
        output reload,
`endif
        input  key_in_rd, round_key, round_key_wr, round_idx, last_round, loaded, blk_count
    );
endinterface

// File: rtl/round_key_sched.sv
// Round-key scheduler: captures NUM_ROUNDS+1 expanded keys, then replays them in order
// forever. Optional macro KEY_RELOAD_EN adds a reload request honoured at sequence boundaries.
module round_key_sched #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic              clock,
    input  logic              reset,
    round_key_sched_if.master bus
);
    typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    state_t       r_state;
    state_t       w_state_next;
    logic [3:0]   r_ptr;
    logic [3:0]   w_ptr_next;
    logic [15:0]  r_blk_count;
    logic [15:0]  w_blk_next;
    logic         w_pop;
    logic         w_push;
    logic         w_at_last;
    logic [127:0] w_store [0:NUM_ROUNDS];
`ifdef KEY_RELOAD_EN
    logic         r_pending;
    logic         w_pending_next;
`endif

    assign w_at_last = (r_ptr == LAST_IDX);

    // One register per key slot; a slot is written only by the pop aimed at it.
    genvar gi;
    generate
        for (gi = 0; gi <= NUM_ROUNDS; gi++) begin : g_store
            logic [127:0] r_key;
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_key <= '0;
                end else if (w_pop && (r_ptr == 4'(gi))) begin
                    r_key <= bus.key_in;
                end
            end
            assign w_store[gi] = r_key;
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_LOAD;
            r_ptr       <= '0;
            r_blk_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_ptr       <= w_ptr_next;
            r_blk_count <= w_blk_next;
        end
    end

`ifdef KEY_RELOAD_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_blk_next   = r_blk_count;
        w_pop        = 1'b0;
        w_push       = 1'b0;
`ifdef KEY_RELOAD_EN
        w_pending_next = 1'b0;
`endif
        case (r_state)
            S_LOAD: begin
                w_pop = !bus.key_in_empty;
                if (w_pop) begin
                    if (w_at_last) begin
                        w_state_next = S_RUN;
                        w_ptr_next   = '0;
                        w_blk_next   = '0;
                    end else begin
                        w_ptr_next = r_ptr + 4'd1;
                    end
                end
            end
            S_RUN: begin
                w_push = !bus.round_key_full;
                if (w_push) begin
                    if (w_at_last) begin
                        w_ptr_next = '0;
                        w_blk_next = r_blk_count + 16'd1;
                    end else begin
                        w_ptr_next = r_ptr + 4'd1;
                    end
                end
`ifdef KEY_RELOAD_EN
                // A pending reload waits for the sequence boundary so no sequence is cut short.
                w_pending_next = r_pending | bus.reload;
                if (r_pending && ((w_push && w_at_last) || ((r_ptr == 4'd0) && !w_push))) begin
                    w_state_next   = S_LOAD;
                    w_pending_next = 1'b0;
                end
`endif
            end
            default: begin
                w_state_next = S_LOAD;
            end
        endcase
    end

    assign bus.key_in_rd    = w_pop;
    assign bus.round_key_wr = w_push;
    assign bus.round_key    = w_push ? w_store[r_ptr] : '0;
    assign bus.round_idx    = r_ptr;
    assign bus.last_round   = (r_state == S_RUN) && w_at_last;
    assign bus.loaded       = (r_state == S_RUN);
    assign bus.blk_count    = r_blk_count;
endmodule

// File: tb/tb_round_key_sched.sv
// Directed bench for round_key_sched (NUM_ROUNDS=10): load, replay, back-pressure,
// stalls, counter wrap, reset mid-run and, when KEY_RELOAD_EN is defined, reload.
module tb_round_key_sched;
    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    round_key_sched_if bus ();

    round_key_sched #(.NUM_ROUNDS(10)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [127:0] mk(input int set, input int idx);
        return {8'(set), {14{8'h5A}}, 8'(idx)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_keys(input int set, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            bus.key_in_empty = 1'b0;
            bus.key_in       = mk(set, first + i);
            #1;
            chk("load_rd", 128'(bus.key_in_rd), 128'(1));
            chk("load_idx", 128'(bus.round_idx), 128'(first + i));
            chk("load_loaded", 128'(bus.loaded), 128'(0));
            chk("load_wr", 128'(bus.round_key_wr), 128'(0));
            chk("load_key0", bus.round_key, 128'(0));
            $display("load set=%0d idx=%0d rd=%0b", set, first + i, bus.key_in_rd);
            step();
        end
        bus.key_in_empty = 1'b1;
    endtask

    task automatic run_keys(input int set, input int first, input int n);
        int e;
        for (int i = 0; i < n; i++) begin
            e = (first + i) % 11;
            bus.round_key_full = 1'b0;
            #1;
            chk("run_wr", 128'(bus.round_key_wr), 128'(1));
            chk("run_key", bus.round_key, mk(set, e));
            chk("run_idx", 128'(bus.round_idx), 128'(e));
            chk("run_last", 128'(bus.last_round), 128'(e == 10));
            chk("run_loaded", 128'(bus.loaded), 128'(1));
            chk("run_rd", 128'(bus.key_in_rd), 128'(0));
            $display("push set=%0d idx=%0d key=%h", set, e, bus.round_key);
            step();
        end
    endtask

    initial begin
        int e;
        reset              = 1'b0;
        bus.key_in         = '0;
        bus.key_in_empty   = 1'b1;
        bus.round_key_full = 1'b1;
`ifdef KEY_RELOAD_EN
        bus.reload         = 1'b0;
`endif
        #1 reset = 1'b1;
        #2;
        chk("rst_rd_empty", 128'(bus.key_in_rd), 128'(0));
        chk("rst_wr", 128'(bus.round_key_wr), 128'(0));
        chk("rst_loaded", 128'(bus.loaded), 128'(0));
        chk("rst_idx", 128'(bus.round_idx), 128'(0));
        chk("rst_last", 128'(bus.last_round), 128'(0));
        chk("rst_blk", 128'(bus.blk_count), 128'(0));
        chk("rst_key", bus.round_key, 128'(0));
        bus.key_in_empty = 1'b0;
        #1;
        chk("rst_rd_avail", 128'(bus.key_in_rd), 128'(1));
        $display("reset state checked");
        step();
        reset = 1'b0;
        bus.key_in_empty = 1'b1;

        // Four keys, a five-cycle upstream stall, then the remaining seven.
        load_keys(0, 0, 4);
        for (int i = 0; i < 5; i++) begin
            bus.key_in_empty = 1'b1;
            #1;
            chk("stall_rd", 128'(bus.key_in_rd), 128'(0));
            chk("stall_idx", 128'(bus.round_idx), 128'(4));
            chk("stall_loaded", 128'(bus.loaded), 128'(0));
            $display("stall cycle=%0d idx=%0d", i, bus.round_idx);
            step();
        end
        load_keys(0, 4, 7);

        run_keys(0, 0, 11);
        #1 chk("blk_after_first", 128'(bus.blk_count), 128'(1));

        // Back-pressure every other cycle across two full sequences.
        e = 0;
        for (int c = 0; c < 44; c++) begin
            bus.round_key_full = (c % 2 == 0);
            #1;
            if (bus.round_key_full) begin
                chk("bp_wr_held", 128'(bus.round_key_wr), 128'(0));
                chk("bp_key_held", bus.round_key, 128'(0));
                chk("bp_idx_held", 128'(bus.round_idx), 128'(e));
            end else begin
                chk("bp_wr", 128'(bus.round_key_wr), 128'(1));
                chk("bp_key", bus.round_key, mk(0, e));
                chk("bp_idx", 128'(bus.round_idx), 128'(e));
                e = (e + 1) % 11;
            end
            $display("bp cycle=%0d full=%0b wr=%0b idx=%0d", c, bus.round_key_full, bus.round_key_wr, bus.round_idx);
            step();
        end
        #1 chk("blk_after_bp", 128'(bus.blk_count), 128'(3));

        // Block counter wraps rather than saturating.
        bus.round_key_full = 1'b1;
        force dut.r_blk_count = 16'hFFFF;
        step();
        release dut.r_blk_count;
        #1 chk("blk_forced", 128'(bus.blk_count), 128'(16'hFFFF));
        run_keys(0, 0, 11);
        #1 chk("blk_wrap", 128'(bus.blk_count), 128'(0));
        $display("blk_count wrap -> %h", bus.blk_count);

        // Reset in the middle of a sequence.
        run_keys(0, 0, 6);
        reset = 1'b1;
        #1;
        chk("midrst_wr", 128'(bus.round_key_wr), 128'(0));
        chk("midrst_loaded", 128'(bus.loaded), 128'(0));
        chk("midrst_idx", 128'(bus.round_idx), 128'(0));
        chk("midrst_key", bus.round_key, 128'(0));
        $display("reset mid-run idx=%0d", bus.round_idx);
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.round_key_full = 1'b0;
            #1 chk("postrst_wr", 128'(bus.round_key_wr), 128'(0));
            step();
        end

        // Partial load discarded by reset, then a full fresh load.
        load_keys(2, 0, 5);
        reset = 1'b1;
        #1 chk("partial_idx", 128'(bus.round_idx), 128'(0));
        step();
        reset = 1'b0;
        load_keys(3, 0, 11);
        run_keys(3, 0, 11);
        #1 chk("blk_fresh", 128'(bus.blk_count), 128'(1));

`ifdef KEY_RELOAD_EN
        run_keys(3, 0, 3);
        bus.reload = 1'b1;
        #1 chk("reload_key3", bus.round_key, mk(3, 3));
        step();
        bus.reload = 1'b0;
        run_keys(3, 4, 7);
        #1;
        chk("reload_loaded", 128'(bus.loaded), 128'(0));
        chk("reload_wr", 128'(bus.round_key_wr), 128'(0));
        bus.key_in_empty = 1'b0;
        #1 chk("reload_rd", 128'(bus.key_in_rd), 128'(1));
        $display("reload entered LOAD");
        load_keys(4, 0, 11);
        run_keys(4, 0, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
